mem_read_arbiter: RTL
=====================

# mem_read_arbiter

Two-port read arbiter and sequencer for the processor's 32x16 synchronous-read program memory. It shares the memory's single address/data port between an instruction-fetch requester (port 0) and a debug/monitor requester (port 1). It also hides the memory's one-cycle registered read latency behind a req/valid handshake. It sits between the processor control unit and the memory, owning the memory address bus exclusively.

## Interface

- AW, 5, address width (memory depth 2^AW words)
- DW, 16, data word width

- MClock  in  1  memory/system clock, all logic on rising edge
- Resetn  in  1  synchronous, active-high reset (asserted = 1, sampled on MClock)
- req0  in  1  port 0 (fetch) read request, level, held until rvalid0
- addr0  in  AW  port 0 read address, stable while req0 high
- req1  in  1  port 1 (debug) read request, level, held until rvalid1
- addr1  in  AW  port 1 read address, stable while req1 high
- gnt0  out  1  port 0 transaction in flight (ISSUE/DATA states)
- gnt1  out  1  port 1 transaction in flight
- rvalid0  out  1  one-cycle pulse: rdata holds port 0 result
- rvalid1  out  1  one-cycle pulse: rdata holds port 1 result
- rdata  out  DW  shared read data, registered, held until next capture
- mem_addr  out  AW  registered address to memory
- mem_data  in  DW  memory read data (valid the cycle after mem_addr sampled)
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, ISSUE, DATA.
- IDLE: if any req high, select winner (see arbitration), latch winner's addr into mem_addr, set gnt of winner, go ISSUE. Else stay.
- ISSUE: memory samples mem_addr at the closing edge. Go DATA unconditionally.
- DATA: rdata <= mem_data; pulse winner's rvalid (visible the cycle after this edge). Clear gnt.
  - Served port's req is ignored at this edge (requester still holds it until it sees rvalid).
  - If the other port's req is high, issue it directly (DATA->ISSUE, new mem_addr, new gnt), else go IDLE.
- Arbitration in IDLE: simultaneous reqs resolved per Configuration. Single req always wins.
- gnt0 and gnt1 never high together. rvalid0 and rvalid1 never high together.
- req dropped before being granted: no transaction. req dropped after grant: transaction completes, rvalid still pulses.
- addr change while granted: ignored, latched address is used.
- mem_addr holds last issued value in IDLE.

## Timing

- Reset (Resetn=1 at an edge): state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, mem_addr=0, busy=0, RR pointer favours port 0. Applies mid-transaction; in-flight read discarded, no rvalid.
- Latency: req sampled at edge E0 in IDLE -> gnt/mem_addr valid after E0 -> memory samples at E1 -> rdata and rvalid valid after E2 for exactly one cycle.
- Isolated read: 3 cycles req-to-rvalid. Single requester repeating back-to-back: one read per 3 cycles (passes through IDLE).
- Both ports continuously requesting: alternating chain ISSUE/DATA, one read per 2 cycles, rvalid of one port coincides with gnt of the other.

## Configuration

- MEM_ARB_ROUND_ROBIN_EN defined: round-robin; on simultaneous req in IDLE, the port not served last wins; pointer updates on each DATA completion.
- Undefined: fixed priority, port 0 (fetch) always wins in IDLE. The DATA->ISSUE handoff to the other port still applies, so port 1 cannot be starved by port 0 alone.

## Test plan

- Reset then req0=1, addr0=5, memory word 5=16'h0040 -> gnt0 after E0, mem_addr=5, rvalid0 one cycle after E2, rdata=16'h0040, busy low after.
- req0 and req1 asserted same edge, addr0=1, addr1=2 -> port 0 first, then port 1 issued straight from DATA; rvalid0 then rvalid1 two cycles apart, rdata matches words 1 and 2.
- Both held high for 6 transactions, ROUND_ROBIN_EN defined -> strict alternation 0,1,0,1,...; undefined -> still alternates via handoff, IDLE ties go to port 0.
- Resetn pulsed during ISSUE of port 1 -> no rvalid1, gnt1=0, mem_addr=0, state IDLE next cycle; new req1 then completes normally.
- req1 pulsed one cycle while port 0 in flight and dropped before grant -> no port 1 transaction, rvalid1 never asserts.
- addr0 changed from 3 to 7 during ISSUE -> returned data is word 3.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: two-port read arbiter and sequencer for a synchronous-read
// program memory. Port 0 is instruction fetch, port 1 is debug/monitor.
// The memory read latency is hidden behind a req / one-cycle rvalid handshake.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests in IDLE go to the port not served last
//   undefined -> port 0 always wins simultaneous requests in IDLE
// In both builds a completing transaction hands the bus directly to the other
// port if it is requesting, so neither port can starve the other.
//
// Note: Resetn is active-high despite its name (asserted = 1).

module mem_read_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          MClock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          port_q, port_d;      // port owning the in-flight transaction
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;      // port served by the most recent completion

  // Round-robin pick: on a tie the port not served last wins.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1 && !r0;
  endfunction
`else
  // Fixed priority pick: port 0 wins whenever it is requesting.
  function automatic logic pick_port(input logic r0, input logic r1);
    return r1 && !r0;
  endfunction
`endif

  // State and registered datapath; reset discards any in-flight read.
  always_ff @(posedge MClock) begin
    if (Resetn) begin
      state_q    <= S_IDLE;
      port_q     <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;             // "last served = 1" favours port 0 first
`endif
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Next-state: arbitrate in IDLE, wait one cycle in ISSUE for the memory to
  // sample the address, capture data in DATA and hand off to the other port.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    rv0_d      = 1'b0;
    rv1_d      = 1'b0;
    win        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          win = pick_port(req0, req1, last_q);
`else
          win = pick_port(req0, req1);
`endif
          port_d     = win;
          mem_addr_d = win ? addr1 : addr0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        rdata_d = mem_data;
        rv0_d   = ~port_q;
        rv1_d   = port_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = port_q;
`endif
        // The served port's request is still high here; only the other port
        // is considered for an immediate back-to-back issue.
        if (port_q ? req0 : req1) begin
          port_d     = ~port_q;
          mem_addr_d = port_q ? addr0 : addr1;
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: grants follow the in-flight owner, everything else is registered.
  always_comb begin
    busy     = (state_q != S_IDLE);
    gnt0     = busy && !port_q;
    gnt1     = busy && port_q;
    rvalid0  = rv0_q;
    rvalid1  = rv1_q;
    rdata    = rdata_q;
    mem_addr = mem_addr_q;
  end

endmodule
